// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared constants and owner type for the data-memory arbiter
package dm_arb_pkg;

    localparam int unsigned DM_WORDS_DEF     = 1024;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam logic [31:0] DMA_PC_DEF       = 32'h0000_0000;
    localparam int unsigned CNT_W            = 4;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - single-port data memory bus between the arbiter and dm
interface dm_arbiter_if;

    logic [31:0] addr;
    logic [31:0] dm_in;
    logic        memwrite;
    logic        memread;
    logic [31:0] pc_new;
    logic [31:0] dm_out;

    modport master (
        output addr, dm_in, memwrite, memread, pc_new,
        input  dm_out
    );

    modport slave (
        input  addr, dm_in, memwrite, memread, pc_new,
        output dm_out
    );

endinterface

// File: rtl/dm_arb_starve_cnt.sv
// rtl/dm_arb_starve_cnt.sv - saturating DMA starvation counter
module dm_arb_starve_cnt
    import dm_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == limit);

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU-priority arbiter sharing dm with a DMA requester
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned DM_WORDS     = DM_WORDS_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [31:0] DMA_PC       = DMA_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    dm_arbiter_if.master dm
);

    localparam logic [32:0]      DM_BYTES = 33'(DM_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

    logic   cpu_req;
    logic   dma_ok;
    logic   starve;
    logic   dma_sel;
    logic   cnt_inc;
    owner_e owner;

    assign cpu_req = cpu_re | cpu_we;
    assign dma_ok  = {1'b0, dma_addr} < DM_BYTES;
    assign dma_sel = dma_req & dma_ok & (!cpu_req | starve);
    // A pending in-range DMA that lost arbitration is the only thing that ages the counter.
    assign cnt_inc = dma_req & dma_ok & !dma_sel;

    dm_arb_starve_cnt u_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_inc),
        .clr      (!cnt_inc),
        .limit    (LIMIT),
        .at_limit (starve)
    );

    always_comb begin
        owner       = (dma_sel && !reset) ? OWN_DMA : OWN_CPU;
        dm.addr     = cpu_addr;
        dm.dm_in    = cpu_wdata;
        dm.pc_new   = cpu_pc;
        dm.memwrite = cpu_we & !reset;
        dm.memread  = cpu_re & !reset;
        cpu_stall   = 1'b0;
        if (owner == OWN_DMA) begin
            dm.addr     = {dma_addr[31:2], 2'b00};
            dm.dm_in    = dma_wdata;
            dm.pc_new   = DMA_PC;
            dm.memwrite = dma_we;
            dm.memread  = !dma_we;
            cpu_stall   = cpu_req;
        end
    end

    // Out-of-range requests are acked with an error immediately and never touch dm.
    assign dma_ack   = !reset & dma_req & (dma_sel | !dma_ok);
    assign dma_err   = !reset & dma_req & !dma_ok;
    assign cpu_rdata = dm.dm_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else if (dma_ack && !dma_we) begin
            dma_rvalid <= 1'b1;
            dma_rdata  <= dma_ok ? dm.dm_out : 32'h0;
        end else begin
            dma_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack, dma_err, dma_rvalid;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];

    dm_arbiter_if dm_bus ();

    dm_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_pc     (cpu_pc),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_err    (dma_err),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dm         (dm_bus)
    );

    always #5 clk = ~clk;

    assign dm_bus.dm_out = mem[dm_bus.addr[11:2]];
    always @(posedge clk) begin
        if (dm_bus.memwrite) mem[dm_bus.addr[11:2]] <= dm_bus.dm_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wcnt();
        return {28'h0, dut.u_cnt.cnt};
    endfunction

    int exp_cnt [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1;
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_pc = 32'h100;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        tick();
        tick();

        // reset state with both sides requesting
        cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h5555_5555;
        dma_req = 1; dma_we = 1; dma_addr = 32'h20;
        #3;
        check("rst_memwrite", {31'h0, dm_bus.memwrite}, 32'h0);
        check("rst_ack", {31'h0, dma_ack}, 32'h0);
        check("rst_stall", {31'h0, cpu_stall}, 32'h0);
        check("rst_addr", dm_bus.addr, 32'h40);
        check("rst_rvalid", {31'h0, dma_rvalid}, 32'h0);
        check("rst_rdata", dma_rdata, 32'h0);
        check("rst_wcnt", wcnt(), 32'h0);
        tick();
        reset = 0; dma_req = 0;

        // CPU-only store then load
        cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678; cpu_pc = 32'h104;
        #3;
        check("cpu_sw_stall", {31'h0, cpu_stall}, 32'h0);
        check("cpu_sw_pc", dm_bus.pc_new, 32'h104);
        check("cpu_sw_memwrite", {31'h0, dm_bus.memwrite}, 32'h1);
        tick();
        cpu_we = 0; cpu_re = 1; cpu_pc = 32'h108;
        #3;
        check("cpu_lw_rdata", cpu_rdata, 32'h1234_5678);
        check("cpu_lw_stall", {31'h0, cpu_stall}, 32'h0);
        check("cpu_lw_pc", dm_bus.pc_new, 32'h108);
        tick();
        cpu_re = 0;

        // DMA write then read with idle CPU
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hDEAD_BEEF;
        #3;
        check("dma_wr_ack", {31'h0, dma_ack}, 32'h1);
        check("dma_wr_pc", dm_bus.pc_new, 32'h0);
        check("dma_wr_err", {31'h0, dma_err}, 32'h0);
        tick();
        dma_we = 0;
        #3;
        check("dma_rd_ack", {31'h0, dma_ack}, 32'h1);
        check("dma_rd_memread", {31'h0, dm_bus.memread}, 32'h1);
        check("dma_rd_pc", dm_bus.pc_new, 32'h0);
        tick();
        dma_req = 0;
        check("dma_rd_rvalid", {31'h0, dma_rvalid}, 32'h1);
        check("dma_rd_rdata", dma_rdata, 32'hDEAD_BEEF);
        tick();
        check("dma_rvalid_drop", {31'h0, dma_rvalid}, 32'h0);

        // contention: CPU load and DMA read held for 12 cycles
        cpu_re = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        for (int c = 1; c <= 12; c++) begin
            #3;
            check($sformatf("cont_ack_c%0d", c), {31'h0, dma_ack}, {31'h0, (c == 5 || c == 10)});
            check($sformatf("cont_stall_c%0d", c), {31'h0, cpu_stall}, {31'h0, (c == 5 || c == 10)});
            check($sformatf("cont_wcnt_c%0d", c), wcnt(), exp_cnt[c-1]);
            tick();
        end
        cpu_re = 0; dma_req = 0;
        tick();

        // out-of-range DMA read during a CPU store
        cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5_0001;
        dma_req = 1; dma_we = 0; dma_addr = 32'd4096;
        #3;
        check("oor_ack", {31'h0, dma_ack}, 32'h1);
        check("oor_err", {31'h0, dma_err}, 32'h1);
        check("oor_stall", {31'h0, cpu_stall}, 32'h0);
        check("oor_addr", dm_bus.addr, 32'h30);
        tick();
        dma_req = 0; cpu_we = 0; cpu_re = 1;
        #3;
        check("oor_rvalid", {31'h0, dma_rvalid}, 32'h1);
        check("oor_rdata", dma_rdata, 32'h0);
        check("oor_cpu_store", cpu_rdata, 32'hA5A5_0001);
        tick();
        cpu_re = 0;

        // unaligned DMA write lands on the containing word
        dma_req = 1; dma_we = 1; dma_addr = 32'h2F; dma_wdata = 32'hCAFE_F00D;
        #3;
        check("unal_ack", {31'h0, dma_ack}, 32'h1);
        check("unal_addr", dm_bus.addr, 32'h2C);
        tick();
        dma_req = 0; cpu_re = 1; cpu_addr = 32'h2C;
        #3;
        check("unal_word", cpu_rdata, 32'hCAFE_F00D);
        tick();
        cpu_re = 0;

        // reset asserted mid-contention at wait_cnt=3
        cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h7777_7777;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        tick(); tick(); tick();
        check("rmc_wcnt3", wcnt(), 32'h3);
        reset = 1;
        #3;
        check("rmc_memwrite", {31'h0, dm_bus.memwrite}, 32'h0);
        check("rmc_ack", {31'h0, dma_ack}, 32'h0);
        tick();
        reset = 0;
        for (int k = 1; k <= 5; k++) begin
            #3;
            check($sformatf("rmc_ack_k%0d", k), {31'h0, dma_ack}, {31'h0, (k == 5)});
            tick();
        end
        dma_req = 0; cpu_we = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory `dm` between the pipeline MEM stage (CPU) and a debug/DMA requester. The CPU has priority. A saturating starvation counter guarantees the DMA side one access slot out of every `STARVE_LIMIT+1` contended cycles, and the CPU is stalled for exactly that slot. The block sits between the MEM-stage pipeline register and `dm`, and drives every `dm` input.

## Interface
- `DM_WORDS`, 1024: number of 32-bit words in `dm`. A valid byte address is below `DM_WORDS*4`.
- `STARVE_LIMIT`, 4: number of contended cycles the DMA waits before it is force-granted. Legal range is 1..15.
- `DMA_PC`, 32'h0000_0000: value driven on `pc_new` during DMA accesses.
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_re` / `cpu_we` in 1 each: MEM-stage load / store request.
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: CPU store data.
- `cpu_pc` in 32: PC of the MEM-stage instruction.
- `cpu_rdata` out 32: load data; combinational from `dm_out`.
- `cpu_stall` out 1: freeze the pipeline this cycle.
- `dma_req` in 1: DMA request; held until `dma_ack`.
- `dma_we` in 1: DMA write (1) or read (0).
- `dma_addr` in 32: DMA byte address.
- `dma_wdata` in 32: DMA write data.
- `dma_ack` out 1: DMA request served this cycle.
- `dma_err` out 1: qualifies `dma_ack`; set when the address is out of range.
- `dma_rdata` out 32: registered DMA read data.
- `dma_rvalid` out 1: one-cycle pulse; `dma_rdata` is valid.
- `addr`, `dm_in`, `memwrite`, `memread`, `pc_new` out 32/32/1/1/32: to `dm`.
- `dm_out` in 32: from `dm`. Reads are combinational; writes land at `posedge clk`.

## Operation
- `cpu_req = cpu_re | cpu_we`.
- `dma_ok = dma_addr < DM_WORDS*4`.
- `starve = wait_cnt == STARVE_LIMIT`.
- `dma_sel = dma_req & dma_ok & (!cpu_req | starve)`. This is combinational, evaluated every cycle.
- When `dma_sel=0`, the CPU owns the port:
  - `addr=cpu_addr`, `dm_in=cpu_wdata`, `memwrite=cpu_we`, `memread=cpu_re`, `pc_new=cpu_pc`.
  - `cpu_stall=0`.
- When `dma_sel=1`, the DMA owns the port:
  - `addr={dma_addr[31:2],2'b00}`, `dm_in=dma_wdata`, `memwrite=dma_we`, `memread=!dma_we`, `pc_new=DMA_PC`.
  - `cpu_stall=cpu_req`, `dma_ack=1`.
- Out-of-range DMA (`dma_req & !dma_ok`):
  - `dma_ack=1` and `dma_err=1` in the same cycle.
  - `dm` is not touched and the CPU keeps the port (no stall).
  - For a read, `dma_rdata` becomes 0 with a `dma_rvalid` pulse.
- `wait_cnt` is 4 bits. At each posedge:
  - clear if `reset`, or `!dma_req`, or `dma_sel`, or `!dma_ok`;
  - else increment, saturating at `STARVE_LIMIT`.
- Read capture: at the posedge of a served DMA read (`dma_ack & !dma_we`):
  - `dma_rdata <= dma_ok ? dm_out : 0`;
  - `dma_rvalid <= 1`.
  - Otherwise `dma_rvalid <= 0` and `dma_rdata` holds.
- Owner states: `OWN_CPU`, `OWN_DMA`. Both are derived from `dma_sel`. `OWN_DMA` never lasts more than one consecutive cycle while `cpu_req=1`, because `wait_cnt` clears after every grant.
- While `reset=1`:
  - `memwrite=0`, `memread=0`, `cpu_stall=0`, `dma_ack=0`, `dma_err=0`.
  - `addr`, `dm_in`, `pc_new` follow the CPU inputs.
  - A DMA request pending across reset is neither acked nor dropped; it is re-arbitrated with `wait_cnt=0` after reset.

## Timing
- Reset values:
  - `wait_cnt=0`, `dma_rvalid=0`, `dma_rdata=0`.
  - All combinational outputs take the values listed under reset above.
- CPU load: 0 extra latency. `cpu_rdata` is valid in the request cycle when not stalled.
- DMA write: committed at the posedge ending the `dma_ack` cycle.
- DMA read: data on `dma_rdata` with `dma_rvalid` one cycle after `dma_ack`.
- DMA handshake:
  - The requester holds `dma_req`/`dma_we`/`dma_addr`/`dma_wdata` stable until it sees `dma_ack`.
  - It may keep `dma_req` high for back-to-back accesses with new address/data.
- Worst-case DMA wait under continuous CPU traffic: `STARVE_LIMIT` cycles. The grant follows in cycle `STARVE_LIMIT+1`.
- CPU bandwidth loss under continuous DMA traffic: 1 stall per `STARVE_LIMIT+1` cycles.
- Idle CPU: DMA is served every cycle.

## Structure
- Package `dm_arb_pkg` holds:
  - `DM_WORDS_DEF`, `STARVE_LIMIT_DEF`, `DMA_PC_DEF`;
  - the owner enum `{OWN_CPU, OWN_DMA}`;
  - the 4-bit counter width constant.
- Sub-module `dm_arb_starve_cnt` is the saturating counter.
  - Inputs: `clk`, `reset`, `inc`, `clr`, `limit`.
  - Output: `at_limit`.
- All muxing and read capture stay in `dm_arbiter`.

## Test plan
- **CPU-only traffic:** `sw` 0x1234_5678 to 0x10, then `lw` 0x10.
  - Required: `cpu_rdata=0x1234_5678`, `cpu_stall` never asserted, `pc_new=cpu_pc`.
- **DMA with idle CPU:** write 0xDEAD_BEEF to 0x20, then read 0x20.
  - Required: `dma_ack` in each request cycle.
  - Required: `dma_rvalid` the next cycle with `dma_rdata=0xDEAD_BEEF`.
  - Required: `pc_new=DMA_PC` in the DMA cycles.
- **Contention, `STARVE_LIMIT=4`:** `cpu_re` and `dma_req` held high for 12 cycles.
  - Required: `dma_ack` and `cpu_stall` in cycles 5 and 10 only.
  - Required: `wait_cnt` reads 0,1,2,3,4,0,1….
- **Out-of-range DMA:** `dma_addr=DM_WORDS*4` during a CPU store.
  - Required: `dma_ack=dma_err=1` in the same cycle, no CPU stall, CPU store committed.
  - Required: `dma_rvalid` next cycle with `dma_rdata=0`.
- **Unaligned DMA:** write to 0x2F.
  - Required: the word at 0x2C is written.
- **Reset mid-contention:** `reset` asserted for 1 cycle when `wait_cnt=3`.
  - Required during reset: `memwrite=0`, `dma_ack=0`.
  - Required after reset: the DMA is granted 5 cycles later, not 1.
